// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the gcd result path.
package gcd_pkg;

  localparam int unsigned GCD_W     = 16;
  localparam int unsigned GCD_TAG_W = 8;

  // One queued result as seen by the consumer.
  typedef struct packed {
    logic [GCD_W-1:0]     data;
    logic [GCD_TAG_W-1:0] tag;
  } gcd_result_t;

  // Occupancy counters must hold 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned GCD_DEPTH   = 4;
  localparam int unsigned GCD_LEVEL_W = level_w(GCD_DEPTH);

endpackage

// File: rtl/gcd_fifo_mem.sv
// Storage array for the gcd result queue: one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module gcd_fifo_mem #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 24
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ENTRY_W-1:0]       rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write the incoming entry at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gcd_result_queue.sv
// Val/rdy result FIFO downstream of gcd. Tags every accepted result with a
// wrapping sequence number and reports occupancy and accepted count.
// Optional statistics (max_level, stall_cycles) when GCD_RESULT_QUEUE_STATS_EN
// is defined.
module gcd_result_queue
  import gcd_pkg::*;
#(
  parameter int unsigned W     = GCD_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = GCD_TAG_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [W-1:0]              result_bits_data,
  input  logic                      result_val,
  output logic                      result_rdy,
  output logic [W-1:0]              sink_bits_data,
  output logic [TAG_W-1:0]          sink_bits_tag,
  output logic                      sink_val,
  input  logic                      sink_rdy,
  output logic [level_w(DEPTH)-1:0] level,
`ifdef GCD_RESULT_QUEUE_STATS_EN
  output logic [level_w(DEPTH)-1:0] max_level,
  output logic [15:0]               stall_cycles,
`endif
  output logic [15:0]               total_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);
  localparam int unsigned E_W   = W + TAG_W;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_ctr;
  logic [E_W-1:0]   rd_entry;
  logic             push;
  logic             pop;

  assign result_rdy = (level != FULL);
  assign sink_val   = (level != '0);
  assign push       = result_val && result_rdy;
  assign pop        = sink_val && sink_rdy;
  assign {sink_bits_data, sink_bits_tag} = rd_entry;

  gcd_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (E_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({result_bits_data, tag_ctr}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Pointers, occupancy, sequence tag and accepted-count bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      tag_ctr     <= '0;
      total_count <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        tag_ctr     <= tag_ctr + TAG_W'(1);
        total_count <= total_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef GCD_RESULT_QUEUE_STATS_EN
  logic [LVL_W-1:0] level_next;

  // Occupancy after this edge, so the high-water mark tracks level exactly.
  always_comb begin
    level_next = level;
    if (push && !pop) level_next = level + LVL_W'(1);
    if (pop && !push) level_next = level - LVL_W'(1);
  end

  // High-water mark and saturating count of cycles gcd was held off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_level    <= '0;
      stall_cycles <= '0;
    end else begin
      if (level_next > max_level) begin
        max_level <= level_next;
      end
      if (result_val && !result_rdy && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
